// File: rtl/pmm_result_reader_if.sv
// Bundle of PMM result channels and the CPU read port.
// The PMMs and the CPU sit on the master side; the reader sits on the slave side.
interface pmm_result_reader_if #(
  parameter int RES_W = 30
);
  logic [3:0]         res_valid;
  logic [4*RES_W-1:0] res_data;
  logic [3:0]         res_ready;
  logic [31:0]        daddr;
  logic               dre;
  logic [31:0]        drdata;

  modport master (
    output res_valid,
    output res_data,
    output daddr,
    output dre,
    input  res_ready,
    input  drdata
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  daddr,
    input  dre,
    output res_ready,
    output drdata
  );
endinterface

// File: rtl/pmm_result_reader.sv
// Collects match results from PMM0..PMM3, arbitrates them round-robin into a
// small FIFO and serves CPU reads of status, FIFO head and accepted counter.
module pmm_result_reader #(
  parameter int RES_W = 30,
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  pmm_result_reader_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [4:0]  COUNT_FULL = 5'(DEPTH);
  localparam logic [29:0] ADDR_STATUS   = 30'd4;
  localparam logic [29:0] ADDR_RESULT   = 30'd5;
  localparam logic [29:0] ADDR_ACCEPTED = 30'd6;

  // FIFO storage and bookkeeping
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [4:0]    count_reg;
  logic [1:0]    rr_ptr_reg;
  logic [15:0]   accepted_reg;
  logic [31:0]   drdata_reg;

  // Arbitration
  logic [1:0]  cand_id   [4];
  logic [3:0]  rot_valid;
  logic [29:0] payload   [4];
  logic        can_push;
  logic        grant_any;
  logic [1:0]  grant_id;
  logic [31:0] push_entry;
  logic        push;

  // CPU read side
  logic [29:0] word_addr;
  logic        is_status;
  logic        is_result;
  logic        is_accepted;
  logic        empty;
  logic        full;
  logic        pop;
  logic [31:0] status_word;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.daddr[1:0];

  // Candidate k is the PMM that sits k places after rr_ptr; rot_valid is the
  // request vector rotated so that index 0 has the highest priority.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_id[gi]   = rr_ptr_reg + 2'(gi);
      assign rot_valid[gi] = bus.res_valid[cand_id[gi]];
      assign payload[gi]   = 30'(bus.res_data[gi*RES_W +: RES_W]);
    end
  endgenerate

  // Full is judged on the registered count only, so a pop in the same cycle
  // never opens a slot early. Nothing is granted while reset is asserted.
  assign full      = (count_reg == COUNT_FULL);
  assign empty     = (count_reg == 5'd0);
  assign can_push  = rst_n && !full;
  assign grant_any = can_push && (|rot_valid);
  assign push      = grant_any;

  // Pick the lowest rotated index that is requesting.
  always_comb begin
    grant_id = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_id = cand_id[k];
      end
    end
  end

  assign bus.res_ready = grant_any ? (4'b0001 << grant_id) : 4'b0000;
  assign push_entry    = {grant_id, payload[grant_id]};

  // Address decode of the CPU word address
  assign word_addr   = bus.daddr[31:2];
  assign is_status   = (word_addr == ADDR_STATUS);
  assign is_result   = (word_addr == ADDR_RESULT);
  assign is_accepted = (word_addr == ADDR_ACCEPTED);
  assign pop         = bus.dre && is_result && !empty;

  assign status_word = {20'd0, bus.res_valid, 1'b0, full, empty, count_reg};

  // Select the word returned for the current read address.
  always_comb begin
    rd_word = 32'd0;
    if (is_status) begin
      rd_word = status_word;
    end else if (is_result) begin
      rd_word = empty ? 32'd0 : mem[rd_ptr_reg];
    end else if (is_accepted) begin
      rd_word = {16'd0, accepted_reg};
    end
  end

  // Entry storage: no reset, stale contents are hidden by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 5'd1;
        2'b01:   count_reg <= count_reg - 5'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Round-robin pointer moves just past the PMM that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= 2'd0;
    end else if (push) begin
      rr_ptr_reg <= grant_id + 2'd1;
    end
  end

  // Free-running count of accepted results, wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_reg <= 16'd0;
    end else if (push) begin
      accepted_reg <= accepted_reg + 16'd1;
    end
  end

  // Read data register: loads on every read strobe and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drdata_reg <= 32'd0;
    end else if (bus.dre) begin
      drdata_reg <= rd_word;
    end
  end

  assign bus.drdata = drdata_reg;

endmodule
